// File: rtl/encoder8_to_3_pend.sv
// encoder8_to_3_pend
//   Pending-request priority encoder with a valid/ack handshake.
//   Request lines are OR-ed into a sticky pending register each edge.
//   The highest-priority pending code is presented on out/valid and held
//   until the consumer acks it. On ack, that bit is cleared and the next
//   pending code is loaded on the same edge, so codes can go back-to-back.
//
// Parameters
//   LOW_FIRST : 1 = bit 0 highest priority, 0 = bit 7 highest priority
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   en     in   capture enable for in
//   in     in   [7:0] request lines, level-sampled each edge
//   ack    in   consumer accepts the presented code
//   out    out  [2:0] code being presented (0 when not valid)
//   valid  out  out holds a pending request awaiting ack
//   multi  out  more than one request was pending when out was loaded
//   pend   out  [7:0] pending-request register
module encoder8_to_3_pend #(
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] in,
  input  logic       ack,
  output logic [2:0] out,
  output logic       valid,
  output logic       multi,
  output logic [7:0] pend
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t     state, state_nxt;
  logic [7:0] clr;
  logic [7:0] pend_nxt;
  logic [7:0] src;
  logic [2:0] out_nxt;
  logic       multi_nxt;

  // Scan from lowest to highest priority; the last set bit seen wins.
  function automatic logic [2:0] enc(input logic [7:0] x);
    logic [2:0] idx;
    int         b;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      b = LOW_FIRST ? (7 - i) : i;
      if (x[b]) idx = 3'(b);
    end
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something only if 2+ bits were set.
  function automatic logic many(input logic [7:0] x);
    return (x & (x - 8'd1)) != 8'd0;
  endfunction

  assign valid    = (state == PRESENT);
  assign clr      = (valid && ack) ? (8'd1 << out) : 8'd0;
  // Set wins over clear: a request arriving with the ack re-arms its bit.
  assign pend_nxt = (pend & ~clr) | (en ? in : 8'd0);
  // Candidates for the next load exclude anything sampled this cycle.
  assign src      = pend & ~clr;

  always_comb begin
    state_nxt = state;
    out_nxt   = out;
    multi_nxt = multi;
    case (state)
      IDLE: begin
        if (src != 8'd0) begin
          state_nxt = PRESENT;
          out_nxt   = enc(src);
          multi_nxt = many(src);
        end
      end
      PRESENT: begin
        // Without ack the presented code is frozen, even if a higher
        // priority request shows up.
        if (ack) begin
          if (src != 8'd0) begin
            out_nxt   = enc(src);
            multi_nxt = many(src);
          end else begin
            state_nxt = IDLE;
            out_nxt   = 3'd0;
            multi_nxt = 1'b0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        out_nxt   = 3'd0;
        multi_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      out   <= 3'd0;
      multi <= 1'b0;
      pend  <= 8'd0;
    end else begin
      state <= state_nxt;
      out   <= out_nxt;
      multi <= multi_nxt;
      pend  <= pend_nxt;
    end
  end

endmodule

// File: doc/encoder8_to_3_pend.md
ENCODER8_TO_3_PEND -- requirements
Module: encoder8_to_3_pend

Interface
REQ-001 Parameter: LOW_FIRST, default 1, 1 = bit 0 highest priority, 0 = bit 7 highest priority.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: en  input  1  capture enable for req; low = new requests ignored.
REQ-005 Port: in  input  8  request lines, one per code, level-sampled each edge.
REQ-006 Port: ack  input  1  consumer accepts presented code this cycle.
REQ-007 Port: out  output  3  binary code of the presented request.
REQ-008 Port: valid  output  1  out holds a pending request awaiting ack.
REQ-009 Port: multi  output  1  more than one request was pending when out was loaded.
REQ-010 Port: pend  output  8  current pending-request register, for observability.

Function
REQ-011 Pending register: each edge, pend_next = (pend & ~clr) | (en ? in : 8'd0); set wins over clear on the same bit.
REQ-012 clr = one-hot of out when valid && ack, else 8'd0.
REQ-013 Encoding: enc(x) = index of highest-priority set bit of x per LOW_FIRST; code i maps to bit in[i].
REQ-014 States: IDLE (valid=0), PRESENT (valid=1); outputs out, valid, multi are registered.
REQ-015 IDLE: if pend != 0, at the edge load out=enc(pend), multi=(popcount(pend)>1), valid=1, go PRESENT; else stay IDLE.
REQ-016 IDLE uses the registered pend only; a request first sampled at edge N appears in pend after edge N and on valid after edge N+1 (2-edge latency).
REQ-017 PRESENT, ack=0: out, multi, valid held stable, regardless of higher-priority arrivals.
REQ-018 PRESENT, ack=1: let r = pend & ~clr; if r != 0, load out=enc(r), multi=(popcount(r)>1), stay PRESENT (back-to-back); else valid=0, out=0, multi=0, go IDLE.
REQ-019 Requests sampled in the same ack cycle are excluded from r; they are served on a later load.
REQ-020 ack while valid=0 is ignored; no state change.
REQ-021 en=0 does not affect pending bits already set; they continue to be presented and cleared.
REQ-022 A req line held high re-sets its pend bit each cycle; the same code is presented again after any ack (no starvation protection; by design).
REQ-023 out equals 3'd0 whenever valid=0.

Reset
REQ-024 rst_n=0 asynchronously forces pend=8'd0, out=3'd0, valid=0, multi=0, state=IDLE, including mid-handshake.
REQ-025 First capture occurs at the first rising edge with rst_n=1; no request is retained across reset.

Verification
REQ-026 Single pulse: en=1, in=8'b0000_1000 for one cycle -> pend=8'h08 next edge, then valid=1, out=3, multi=0; ack=1 one cycle -> valid=0, pend=8'h00.
REQ-027 Priority/back-to-back: LOW_FIRST=1, in=8'b1010_0100 pulse -> out=2, multi=1; ack held high -> out=5 (multi=1), then out=7 (multi=0), then valid=0; codes on consecutive cycles.
REQ-028 Stability: valid=1 with out=6 and ack=0, then pulse in=8'h01 -> out stays 6 until ack; next presented code is 0.
REQ-029 Enable gating: en=0, in=8'hFF for 5 cycles -> pend=8'h00, valid=0; then en=1, in=8'h80 pulse -> out=7.
REQ-030 Set-wins/reset: out=4 presented, ack=1 with in=8'h10 same cycle -> pend bit 4 remains set, out=4 presented again; assert rst_n=0 mid-cycle -> pend=0, valid=0, out=0 immediately without a clock edge.
